cla_serial_subtractor: RTL and testbench



---
 rtl/cla_serial_subtractor.sv | 122 ++++++++++++
 tb/tb_cla_serial_subtractor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_serial_subtractor.sv
// cla_serial_subtractor
//   Multi-cycle subtractor: diff = a - b, computed as a + ~b + 1 one
//   SLICE-bit lookahead slice per clock, least-significant slice first.
//   The inter-slice carry lives in a register.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   in_valid/in_ready  operand handshake (ready only in IDLE)
//   a, b               minuend, subtrahend (WIDTH bits)
//   out_valid/out_ready result handshake (valid only in DONE)
//   diff               a - b modulo 2^WIDTH
//   borrow             unsigned a < b
//   overflow           signed overflow of a - b
module cla_serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);
    localparam int NS = WIDTH / SLICE;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;

    // Current slice: a + ~b + carry with generate/propagate lookahead.
    logic [SLICE-1:0] sa, sb_n, g, p, s;
    logic [SLICE:0]   c;
    logic             term, acc;

    always_comb begin
        sa   = a_r[idx*SLICE +: SLICE];
        sb_n = ~b_r[idx*SLICE +: SLICE];
        g    = sa & sb_n;
        p    = sa ^ sb_n;
        c    = '0;
        c[0] = carry;
        term = 1'b0;
        acc  = 1'b0;
        // Each c[k+1] is a flat sum of products of g, p and the slice
        // carry-in, so no carry depends on a lower-order computed carry.
        for (int k = 0; k < SLICE; k++) begin
            term = carry;
            for (int j = 0; j <= k; j++) term = term & p[j];
            acc = term;
            for (int j = 0; j <= k; j++) begin
                term = g[j];
                for (int m = j + 1; m <= k; m++) term = term & p[m];
                acc = acc | term;
            end
            c[k+1] = acc;
        end
        s = p ^ c[SLICE-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            diff      <= '0;
            borrow    <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        b_r      <= b;
                        carry    <= 1'b1;   // the +1 of two's complement
                        idx      <= '0;
                        diff     <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    diff[idx*SLICE +: SLICE] <= s;
                    carry                    <= c[SLICE];
                    if (idx == IW'(NS - 1)) begin
                        idx       <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                        borrow    <= ~c[SLICE];
                        // s[SLICE-1] is the final diff MSB being written now.
                        overflow  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                                     (s[SLICE-1] != a_r[WIDTH-1]);
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_serial_subtractor.sv
// Bench for cla_serial_subtractor: 16/4 instance with directed, abort and
// random transactions checked against an arithmetic model, plus a 4/4
// (single-slice) instance.
module tb_cla_serial_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 16-bit instance
    logic        in_valid = 0, in_ready, out_valid, out_ready = 0;
    logic [15:0] a = 0, b = 0, diff;
    logic        borrow, overflow;

    cla_serial_subtractor #(.WIDTH(16), .SLICE(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow), .overflow(overflow));

    // 4-bit single-slice instance
    logic       v_in_valid = 0, v_in_ready, v_out_valid, v_out_ready = 1;
    logic [3:0] v_a = 0, v_b = 0, v_diff;
    logic       v_borrow, v_overflow;

    cla_serial_subtractor #(.WIDTH(4), .SLICE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v_in_valid), .in_ready(v_in_ready),
        .a(v_a), .b(v_b), .out_valid(v_out_valid), .out_ready(v_out_ready),
        .diff(v_diff), .borrow(v_borrow), .overflow(v_overflow));

    int tests = 0, fails = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic.
    function automatic void model16(input logic [15:0] x, input logic [15:0] y,
                                    output logic [15:0] d, output logic br, output logic ov);
        int r;
        d  = x - y;
        br = (x < y);
        r  = int'($signed(x)) - int'($signed(y));
        ov = (r > 32767) || (r < -32768);
    endfunction

    logic        exp_live = 0, seen = 0;
    logic [15:0] exp_d;
    logic        exp_b, exp_o;
    int          acc_cyc;

    // Single compare process for the 16-bit instance.
    always @(negedge clk) begin
        if (!rst) begin
            check("ready_valid_exclusive", in_ready & out_valid, 0);
            if (!exp_live) check("out_valid_without_txn", out_valid, 0);
            else if (out_valid) begin
                check("diff", diff, exp_d);
                check("borrow", borrow, exp_b);
                check("overflow", overflow, exp_o);
                if (!seen) begin
                    check("latency", cyc - acc_cyc, 4);
                    seen = 1;
                end
            end
        end
    end

    task automatic run(input logic [15:0] ta, input logic [15:0] tb_, input int hold,
                       input bit noise, output logic [15:0] rd, output logic rb, output logic ro);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        check("in_ready_before_issue", in_ready, 1);
        in_valid = 1; a = ta; b = tb_;
        @(posedge clk);
        model16(ta, tb_, exp_d, exp_b, exp_o);
        exp_live = 1; seen = 0;
        @(negedge clk);
        acc_cyc = cyc;
        in_valid = 0; a = 16'($urandom); b = 16'($urandom);
        if (noise) begin
            in_valid = 1;
            check("in_ready_busy", in_ready, 0);
        end
        out_ready = (hold == 0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk); n++;
            if (noise) begin a = 16'($urandom); b = 16'($urandom); end
        end
        check("out_valid_timeout", out_valid, 1);
        rd = diff; rb = borrow; ro = overflow;
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check("held_out_valid", out_valid, 1);
            check("in_ready_done", in_ready, 0);
            out_ready = 1;
        end
        in_valid = 0;
        @(posedge clk);
        exp_live = 0;
        @(negedge clk);
        out_ready = 0;
        check("in_ready_after_accept", in_ready, 1);
        check("out_valid_after_accept", out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] rd, ta, tb_;
        logic        rb, ro;
        logic [3:0]  x4, y4;
        int          r4;

        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
        check("rst_overflow", overflow, 0);
        check("rst4_in_ready", v_in_ready, 1);
        check("rst4_out_valid", v_out_valid, 0);
        rst = 0;
        @(negedge clk);

        // Directed cases with hand-computed results.
        run(16'h000A, 16'h000A, 0, 0, rd, rb, ro);
        check("eq_diff", rd, 16'h0000); check("eq_b", rb, 0); check("eq_o", ro, 0);
        run(16'h0000, 16'h0001, 0, 0, rd, rb, ro);
        check("wrap_diff", rd, 16'hFFFF); check("wrap_b", rb, 1); check("wrap_o", ro, 0);
        run(16'h8000, 16'h0001, 0, 0, rd, rb, ro);
        check("ovn_diff", rd, 16'h7FFF); check("ovn_b", rb, 0); check("ovn_o", ro, 1);
        run(16'h7FFF, 16'hFFFF, 0, 0, rd, rb, ro);
        check("ovp_diff", rd, 16'h8000); check("ovp_b", rb, 1); check("ovp_o", ro, 1);
        run(16'h1234, 16'h0234, 3, 1, rd, rb, ro);
        check("bp_diff", rd, 16'h1000); check("bp_b", rb, 0); check("bp_o", ro, 0);

        // Reset in the second BUSY cycle aborts the operation.
        in_valid = 1; a = 16'hFFFF; b = 16'h0F0F;
        @(posedge clk);          // accept
        @(posedge clk);          // first slice
        @(negedge clk);
        in_valid = 0;
        rst = 1;
        #1;
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow, 0);
        check("abort_overflow", overflow, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 0;
        check("abort_ready_release", in_ready, 1);
        repeat (8) @(negedge clk);   // compare process flags any out_valid
        run(16'hC01C, 16'h4011, 0, 0, rd, rb, ro);
        check("post_diff", rd, 16'h800B); check("post_b", rb, 0); check("post_o", ro, 0);

        // Randomized, with some boundary operands mixed in.
        for (int i = 0; i < 40; i++) begin
            ta  = (i % 5 == 0) ? 16'h8000 : 16'($urandom);
            tb_ = (i % 7 == 0) ? ta : ((i % 6 == 0) ? 16'h7FFF : 16'($urandom));
            run(ta, tb_, int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)), rd, rb, ro);
        end

        // Single-slice instance: result one cycle after accept.
        v_in_valid = 1; v_a = 4'b1001; v_b = 4'b1110;
        @(posedge clk);
        @(negedge clk);
        v_in_valid = 0;
        check("w4_not_yet", v_out_valid, 0);
        @(negedge clk);
        check("w4_valid", v_out_valid, 1);
        check("w4_diff", v_diff, 4'b1011);
        check("w4_borrow", v_borrow, 1);
        check("w4_overflow", v_overflow, 0);
        @(negedge clk);
        check("w4_drop", v_out_valid, 0);
        check("w4_ready", v_in_ready, 1);
        for (int i = 0; i < 10; i++) begin
            x4 = 4'($urandom); y4 = 4'($urandom);
            v_in_valid = 1; v_a = x4; v_b = y4;
            @(posedge clk);
            @(negedge clk);
            v_in_valid = 0;
            @(negedge clk);
            r4 = int'($signed(x4)) - int'($signed(y4));
            check("w4r_valid", v_out_valid, 1);
            check("w4r_diff", v_diff, 4'(x4 - y4));
            check("w4r_borrow", v_borrow, x4 < y4);
            check("w4r_overflow", v_overflow, (r4 > 7) || (r4 < -8));
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
